// File: rtl/isa_regfile.sv
// 16 x 64-bit general-purpose register file: one write strobe, two registered
// read ports with write-first bypass, sequential bulk clear, written-since-clear mask.
module isa_regfile_rdport #(
  parameter int NREGS = 16,
  parameter int WIDTH = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NREGS-1:0][WIDTH-1:0] i_nxt,
  input  logic [3:0]                  i_rd_id,
  output logic [WIDTH-1:0]            o_rd_data
);
  // i_nxt is the post-edge register image, so bypass and clear-to-zero fall out for free
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) o_rd_data <= '0;
    else        o_rd_data <= i_nxt[i_rd_id];
  end
endmodule

module isa_regfile #(
  parameter int NREGS = 16,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       reg_id,
  input  logic [WIDTH-1:0] reg_wd,
  input  logic             reg_we,
  input  logic [3:0]       rd_id_a,
  output logic [WIDTH-1:0] rd_data_a,
  input  logic [3:0]       rd_id_b,
  output logic [WIDTH-1:0] rd_data_b,
  input  logic             clr_all,
  output logic             busy,
  output logic [NREGS-1:0] written
);
  typedef enum logic {IDLE, CLEARING} state_t;

  state_t                      r_state;
  logic [3:0]                  r_cnt;
  logic                        r_busy;
  logic [NREGS-1:0]            r_written;
  logic [NREGS-1:0][WIDTH-1:0] r_regs;
  logic [NREGS-1:0][WIDTH-1:0] w_nxt;
  logic                        w_wr_acc;
  logic                        w_clr_en;
  logic [1:0][3:0]             w_rd_id;
  logic [1:0][WIDTH-1:0]       w_rd_data;

  // a clear request on the same edge pre-empts the write
  assign w_wr_acc = (r_state == IDLE) && reg_we && !clr_all;
  assign w_clr_en = (r_state == CLEARING);

  always_comb begin
    w_nxt = r_regs;
    for (int i = 0; i < NREGS; i++) begin
      if (w_clr_en && r_cnt == 4'(i))        w_nxt[i] = '0;
      else if (w_wr_acc && reg_id == 4'(i))  w_nxt[i] = reg_wd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_written <= '0;
      r_regs    <= '0;
    end else begin
      r_regs <= w_nxt;
      case (r_state)
        IDLE: begin
          if (clr_all) begin
            r_state <= CLEARING;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end else if (reg_we) begin
            r_written[reg_id] <= 1'b1;
          end
        end
        CLEARING: begin
          r_written[r_cnt] <= 1'b0;
          r_cnt            <= r_cnt + 4'd1;
          if (r_cnt == 4'(NREGS-1)) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_rd_id = {rd_id_b, rd_id_a};

  for (genvar p = 0; p < 2; p++) begin : g_rd
    isa_regfile_rdport #(.NREGS(NREGS), .WIDTH(WIDTH)) u_rd (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_nxt     (w_nxt),
      .i_rd_id   (w_rd_id[p]),
      .o_rd_data (w_rd_data[p])
    );
  end

  assign rd_data_a = w_rd_data[0];
  assign rd_data_b = w_rd_data[1];
  assign busy      = r_busy;
  assign written   = r_written;
endmodule

// File: tb/tb_isa_regfile.sv
// Directed-vector bench for isa_regfile: reset, write/read, bypass, bulk clear,
// arbitration against writes, and asynchronous reset in the middle of a clear.
module tb_isa_regfile;
  logic        clk;
  logic        rst_n;
  logic [3:0]  reg_id;
  logic [63:0] reg_wd;
  logic        reg_we;
  logic [3:0]  rd_id_a;
  logic [63:0] rd_data_a;
  logic [3:0]  rd_id_b;
  logic [63:0] rd_data_b;
  logic        clr_all;
  logic        busy;
  logic [15:0] written;

  int n_cmp = 0;
  int n_bad = 0;

  isa_regfile dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .reg_id    (reg_id),
    .reg_wd    (reg_wd),
    .reg_we    (reg_we),
    .rd_id_a   (rd_id_a),
    .rd_data_a (rd_data_a),
    .rd_id_b   (rd_id_b),
    .rd_data_b (rd_data_b),
    .clr_all   (clr_all),
    .busy      (busy),
    .written   (written)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // inputs change 1ns after an edge, outputs sampled there too
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] id, input logic [63:0] d);
    reg_we = 1'b1; reg_id = id; reg_wd = d;
    tick();
    reg_we = 1'b0;
  endtask

  task automatic fill();
    for (int i = 0; i < 16; i++) wr(4'(i), 64'(i + 1));
  endtask

  initial begin
    logic [15:0] exp_w;
    rst_n = 1'b0; reg_id = '0; reg_wd = '0; reg_we = 1'b0;
    rd_id_a = '0; rd_id_b = '0; clr_all = 1'b0;
    #12;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_written", 64'(written), 64'd0);
    chk("rst_rda", rd_data_a, 64'd0);
    chk("rst_rdb", rd_data_b, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    tick();

    for (int i = 0; i < 16; i++) begin
      rd_id_a = 4'(i); rd_id_b = 4'(15 - i);
      tick();
      chk("init_rda", rd_data_a, 64'd0);
      chk("init_rdb", rd_data_b, 64'd0);
    end
    chk("init_written", 64'(written), 64'd0);

    // basic write then read on both ports
    wr(4'd3, 64'hDEADBEEF_01234567);
    rd_id_a = 4'd3; rd_id_b = 4'd5;
    tick();
    chk("r3_a", rd_data_a, 64'hDEADBEEF_01234567);
    chk("r5_b", rd_data_b, 64'd0);
    chk("written_r3", 64'(written), 64'h0008);

    // same-edge write/read bypass, plus both ports on one index
    rd_id_a = 4'd7; rd_id_b = 4'd7;
    wr(4'd7, 64'h55);
    chk("bypass_a", rd_data_a, 64'h55);
    chk("bypass_b", rd_data_b, 64'h55);
    chk("written_r7", 64'(written), 64'h0088);

    // fill and bulk clear, watching r15 and the mask shrink
    fill();
    chk("fill_written", 64'(written), 64'hFFFF);
    rd_id_a = 4'd15; rd_id_b = 4'd0;
    clr_all = 1'b1;
    tick();
    clr_all = 1'b0;
    chk("clr_busy_N", 64'(busy), 64'd1);
    chk("clr_r15_N", rd_data_a, 64'd16);
    for (int k = 1; k <= 16; k++) begin
      if (k == 5) begin reg_we = 1'b1; reg_id = 4'd2; reg_wd = 64'h9; end
      if (k == 8) clr_all = 1'b1;
      tick();
      reg_we = 1'b0; clr_all = 1'b0;
      exp_w = 16'hFFFF << k;
      chk("clr_written", 64'(written), 64'(exp_w));
      chk("clr_busy", 64'(busy), (k < 16) ? 64'd1 : 64'd0);
      chk("clr_r15", rd_data_a, (k < 16) ? 64'd16 : 64'd0);
    end
    tick();
    chk("post_busy", 64'(busy), 64'd0);
    rd_id_a = 4'd2; rd_id_b = 4'd9;
    tick();
    chk("drop_r2", rd_data_a, 64'd0);
    chk("post_r9", rd_data_b, 64'd0);
    chk("post_written", 64'(written), 64'd0);

    // asynchronous reset with the counter at 6
    fill();
    rd_id_a = 4'd12; rd_id_b = 4'd3;
    clr_all = 1'b1;
    tick();
    clr_all = 1'b0;
    for (int k = 1; k <= 6; k++) tick();
    chk("mid_r12", rd_data_a, 64'd13);
    chk("mid_written", 64'(written), 64'hFFC0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_written", 64'(written), 64'd0);
    chk("arst_rda", rd_data_a, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    tick();
    chk("arst_busy2", 64'(busy), 64'd0);
    for (int i = 0; i < 16; i++) begin
      rd_id_a = 4'(i); rd_id_b = 4'(i);
      tick();
      chk("arst_rd_a", rd_data_a, 64'd0);
      chk("arst_rd_b", rd_data_b, 64'd0);
    end

    // clear and write on the same edge: clear wins
    reg_we = 1'b1; reg_id = 4'd4; reg_wd = 64'h77; clr_all = 1'b1;
    rd_id_a = 4'd4;
    tick();
    reg_we = 1'b0; clr_all = 1'b0;
    chk("arb_busy", 64'(busy), 64'd1);
    chk("arb_written", 64'(written), 64'd0);
    chk("arb_rd_edge", rd_data_a, 64'd0);
    for (int k = 1; k <= 16; k++) tick();
    chk("arb_busy_end", 64'(busy), 64'd0);
    tick();
    chk("arb_r4", rd_data_a, 64'd0);

    // write accepted right after the clear ends
    wr(4'd4, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("late_r4", rd_data_a, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("late_written", 64'(written), 64'h0010);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
